contadores: RTL and testbench
=============================

CONTADORES -- requirements
Module: contadores

Interface
REQ-001 The block SHALL expose exactly the ports in REQ-002..REQ-009, with no parameters, using one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_L  input  1  asynchronous, active-low reset.
REQ-004 pop_0, pop_1, pop_2, pop_3, pop_4  input  1 each  pop strobe from FIFO n; one count per cycle high.
REQ-005 req  input  1  read request for the counter selected by idx.
REQ-006 idx  input  3  counter select, sampled with req; legal values 0..4.
REQ-007 valid  output  1  data_out carries a counter value this cycle.
REQ-008 data_out  output  5  counter value returned for the accepted request.
REQ-009 idle  output  1  FSM is in IDLE.

Function
REQ-010 The block SHALL hold five independent 5-bit counters, cnt[0..4], one per pop input.
REQ-011 The block SHALL increment cnt[n] by 1 on each rising edge where pop_n=1 and the FSM is in IDLE or ACTIVE.
REQ-012 The counters SHALL wrap modulo 32: 31+1 gives 0, with no flag and no saturation.
REQ-013 Simultaneous pops on any subset of inputs SHALL each increment their own counter in the same cycle.
REQ-014 A request (req=1, idx 0..4) SHALL be answered with exactly 1 cycle of latency: next cycle valid=1 and data_out=cnt[idx] as it was before that edge's update.
REQ-015 If a pop on counter n and a read of counter n occur in the same cycle, the read SHALL return the pre-increment value and the counter SHALL still increment.
REQ-016 Back-to-back requests on consecutive cycles SHALL each be answered; valid stays high for every answered cycle.
REQ-017 A request with idx 5..7 SHALL be ignored: the next cycle has valid=0 and data_out=0.
REQ-018 When valid=0, data_out SHALL be 0.
REQ-019 The FSM SHALL have the states RESET, IDLE and ACTIVE.
REQ-020 The FSM SHALL move from RESET to IDLE on the first rising edge with reset_L=1, and SHALL ignore pops and req on that edge.
REQ-021 The FSM SHALL move from IDLE to ACTIVE on an edge where any pop_n=1 or req=1.
REQ-022 The FSM SHALL move from ACTIVE to IDLE on an edge where all pops are 0 and req=0.
REQ-023 The idle output SHALL be 1 only in IDLE.

Reset
REQ-024 While reset_L=0, asynchronously: all cnt=0, valid=0, data_out=0, idle=0, FSM=RESET.
REQ-025 Asserting reset mid-operation SHALL discard any pending read response and all counts immediately, without waiting for a clock edge.

Configuration
REQ-026 Macro CONTADORES_CLEAR_ON_READ_EN, when defined, SHALL clear cnt[idx] on the edge that accepts its read.
REQ-027 With CONTADORES_CLEAR_ON_READ_EN defined, a pop on the same counter in that cycle SHALL leave the counter at 1.
REQ-028 With CONTADORES_CLEAR_ON_READ_EN undefined, reads SHALL be non-destructive.

Structure
REQ-029 A shared package contadores_pkg SHALL hold NUM_CNT=5, CNT_W=5, IDX_W=3 and the FSM state encoding typedef.
REQ-030 One sub-module, counter_unit (a 5-bit counter with inc and clr inputs, async active-low reset), SHALL be instantiated five times.

Verification
REQ-031 Bench: reset_L=0 for 2 cycles, then 1 -> valid=0, data_out=0, idle=0 during reset; idle=1 two edges after release.
REQ-032 Bench: pop_0=1 for 2 cycles, then req=1, idx=0 -> next cycle valid=1, data_out=2.
REQ-033 Bench: pop_1 for 1 cycle, then req with idx=1 on two consecutive cycles -> data_out=1 on both (macro off), or 1 then 0 (macro on).
REQ-034 Bench: pop_4 held high for 33 cycles, then read idx=4 -> data_out=1 (wrap).
REQ-035 Bench: pop_2=1 and req idx=2 in the same cycle after 3 prior pops -> data_out=3; a subsequent read returns 4 (macro off) or 1 (macro on).
REQ-036 Bench: req with idx=6 -> valid=0 next cycle; reset_L pulsed low while valid=1 -> valid=0 and all counters read back 0.

Source files
------------

// File: rtl/contadores_pkg.sv
// Shared constants, FSM state encoding and index helper for the pop-counter block.
// Optional feature: CONTADORES_CLEAR_ON_READ_EN (clear-on-read) is handled in contadores.sv.
package contadores_pkg;

    localparam int NUM_CNT = 5;
    localparam int CNT_W   = 5;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    function automatic logic idx_legal(input logic [IDX_W-1:0] idx);
        return idx < IDX_W'(NUM_CNT);
    endfunction

endpackage

// File: rtl/contadores_if.sv
// Pop strobes, read request and read response of the counter block, bundled for benches and wrappers.
// master drives pops/requests; slave (the counter block side) returns the response.
interface contadores_if
    import contadores_pkg::*;
(
    input logic clk
);
    logic [NUM_CNT-1:0] pop;
    logic               req;
    logic [IDX_W-1:0]   idx;
    logic               valid;
    logic [CNT_W-1:0]   data_out;
    logic               idle;

    modport master (
        input  clk,
        output pop, req, idx,
        input  valid, data_out, idle
    );

    modport slave (
        input  clk,
        input  pop, req, idx,
        output valid, data_out, idle
    );
endinterface

// File: rtl/counter_unit.sv
// Single wrapping counter with increment and clear; clear wins over the old value but a
// coincident increment still lands, so clear+inc leaves 1. One-cycle update, no backpressure.
module counter_unit
    import contadores_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/contadores.sv
// Five per-FIFO pop counters with a one-cycle-latency read port; reads return pre-update values.
// Latency 1 cycle, no backpressure; CONTADORES_CLEAR_ON_READ_EN makes reads destructive.
module contadores
    import contadores_pkg::*;
(
    input  logic             clk,
    input  logic             reset_L,
    input  logic             pop_0,
    input  logic             pop_1,
    input  logic             pop_2,
    input  logic             pop_3,
    input  logic             pop_4,
    input  logic             req,
    input  logic [IDX_W-1:0] idx,
    output logic             valid,
    output logic [CNT_W-1:0] data_out,
    output logic             idle
);

    state_t             state, state_nxt;
    logic               run;
    logic               rd_ok;
    logic [NUM_CNT-1:0] pop_vec;
    logic [NUM_CNT-1:0] rd_clr;
    logic [CNT_W-1:0]   cnt [NUM_CNT];
    logic [CNT_W-1:0]   rd_dat;

    assign pop_vec = {pop_4, pop_3, pop_2, pop_1, pop_0};
    // The RESET->IDLE edge is a dead cycle: neither pops nor requests are taken on it.
    assign run     = (state != ST_RESET);
    assign rd_ok   = run && req && idx_legal(idx);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= ST_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idle      = 1'b0;
        case (state)
            ST_RESET: begin
                state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                idle = 1'b1;
                if ((|pop_vec) || req) state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!(|pop_vec) && !req) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_RESET;
            end
        endcase
    end

    always_comb begin
        rd_clr = '0;
`ifdef CONTADORES_CLEAR_ON_READ_EN
        for (int n = 0; n < NUM_CNT; n++) begin
            if (rd_ok && (idx == IDX_W'(n))) rd_clr[n] = 1'b1;
        end
`endif
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        counter_unit u_cnt (
            .clk   (clk),
            .rst_n (reset_L),
            .inc   (run && pop_vec[g]),
            .clr   (rd_clr[g]),
            .cnt   (cnt[g])
        );
    end

    always_comb begin
        rd_dat = '0;
        for (int n = 0; n < NUM_CNT; n++) begin
            if (idx == IDX_W'(n)) rd_dat = cnt[n];
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid    <= 1'b0;
            data_out <= '0;
        end else begin
            valid    <= rd_ok;
            data_out <= rd_ok ? rd_dat : '0;
        end
    end

endmodule

// File: tb/tb_contadores.sv
// Directed bench for contadores: behavioural per-FIFO count model checked every cycle,
// plus literal expectations for the reset, read, wrap, same-cycle and illegal-index scenarios.
module tb_contadores;
    import contadores_pkg::*;

`ifdef CONTADORES_CLEAR_ON_READ_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_L;
    always #5 clk = ~clk;

    contadores_if bus (.clk(clk));

    contadores dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .pop_0    (bus.pop[0]),
        .pop_1    (bus.pop[1]),
        .pop_2    (bus.pop[2]),
        .pop_3    (bus.pop[3]),
        .pop_4    (bus.pop[4]),
        .req      (bus.req),
        .idx      (bus.idx),
        .valid    (bus.valid),
        .data_out (bus.data_out),
        .idle     (bus.idle)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: counts per FIFO as plain integers, answer = count before the edge.
    int m_cnt [NUM_CNT];
    bit m_up;
    bit e_vld;
    int e_dat;
    bit e_idle;

    always @(posedge clk or negedge reset_L) begin : model
        int nxt;
        bit legal;
        if (!reset_L) begin
            for (int n = 0; n < NUM_CNT; n++) m_cnt[n] <= 0;
            m_up   <= 1'b0;
            e_vld  <= 1'b0;
            e_dat  <= 0;
            e_idle <= 1'b0;
        end else if (!m_up) begin
            m_up   <= 1'b1;
            e_vld  <= 1'b0;
            e_dat  <= 0;
            e_idle <= 1'b1;
        end else begin
            legal = bus.req && (int'(bus.idx) < NUM_CNT);
            e_vld <= legal;
            e_dat <= legal ? m_cnt[bus.idx] : 0;
            for (int n = 0; n < NUM_CNT; n++) begin
                nxt = bus.pop[n] ? (m_cnt[n] + 1) % 32 : m_cnt[n];
                if (CLR && legal && int'(bus.idx) == n) nxt = bus.pop[n] ? 1 : 0;
                m_cnt[n] <= nxt;
            end
            e_idle <= !((|bus.pop) || bus.req);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_valid", 32'(bus.valid), 32'(e_vld));
            check("cyc_data", 32'(bus.data_out), 32'(e_dat));
            check("cyc_idle", 32'(bus.idle), 32'(e_idle));
        end
    end

    task automatic step(input logic [4:0] p, input logic r, input logic [2:0] i);
        bus.pop = p;
        bus.req = r;
        bus.idx = i;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_L = 1'b0;
        bus.pop = '0;
        bus.req = 1'b0;
        bus.idx = '0;
        @(negedge clk);
        cmp_en = 1'b1;

        // Reset held two cycles
        step(5'b0, 1'b0, 3'd0);
        step(5'b0, 1'b0, 3'd0);
        check("rst_valid", 32'(bus.valid), 0);
        check("rst_data", 32'(bus.data_out), 0);
        check("rst_idle", 32'(bus.idle), 0);
        reset_L = 1'b1;
        step(5'b0, 1'b0, 3'd0);
        step(5'b0, 1'b0, 3'd0);
        check("rel_idle", 32'(bus.idle), 1);

        // Two pops on FIFO 0, then read
        step(5'b00001, 1'b0, 3'd0);
        check("act_idle", 32'(bus.idle), 0);
        step(5'b00001, 1'b0, 3'd0);
        step(5'b00000, 1'b1, 3'd0);
        check("rd0_valid", 32'(bus.valid), 1);
        check("rd0_data", 32'(bus.data_out), 2);

        // One pop on FIFO 1, back-to-back reads
        step(5'b00010, 1'b0, 3'd0);
        step(5'b00000, 1'b1, 3'd1);
        check("rd1a_data", 32'(bus.data_out), 1);
        step(5'b00000, 1'b1, 3'd1);
        check("rd1b_valid", 32'(bus.valid), 1);
        check("rd1b_data", 32'(bus.data_out), CLR ? 0 : 1);
        step(5'b00000, 1'b0, 3'd0);
        check("norq_valid", 32'(bus.valid), 0);
        check("norq_data", 32'(bus.data_out), 0);

        // 33 pops on FIFO 4 wrap to 1
        for (int k = 0; k < 33; k++) step(5'b10000, 1'b0, 3'd0);
        step(5'b00000, 1'b1, 3'd4);
        check("wrap4_data", 32'(bus.data_out), 1);

        // Pop and read of FIFO 2 in the same cycle after three pops
        for (int k = 0; k < 3; k++) step(5'b00100, 1'b0, 3'd0);
        step(5'b00100, 1'b1, 3'd2);
        check("same2_data", 32'(bus.data_out), 3);
        step(5'b00000, 1'b1, 3'd2);
        check("after2_data", 32'(bus.data_out), CLR ? 1 : 4);

        // All FIFOs pop together
        step(5'b11111, 1'b0, 3'd0);
        step(5'b00000, 1'b1, 3'd3);
        check("all3_data", 32'(bus.data_out), 1);

        // Illegal index
        step(5'b00000, 1'b1, 3'd6);
        check("ill_valid", 32'(bus.valid), 0);
        check("ill_data", 32'(bus.data_out), 0);

        // Reset pulse while a response is on the bus
        step(5'b00000, 1'b1, 3'd0);
        check("pre_rst_valid", 32'(bus.valid), 1);
        bus.req = 1'b0;
        #2;
        reset_L = 1'b0;
        #1;
        check("arst_valid", 32'(bus.valid), 0);
        check("arst_data", 32'(bus.data_out), 0);
        check("arst_idle", 32'(bus.idle), 0);
        @(negedge clk);
        step(5'b00000, 1'b0, 3'd0);
        reset_L = 1'b1;
        // Pops on the release edge must be ignored
        step(5'b11111, 1'b1, 3'd0);
        check("rel_ign_valid", 32'(bus.valid), 0);
        for (int k = 0; k < NUM_CNT; k++) begin
            step(5'b00000, 1'b1, 3'(k));
            check("clr_valid", 32'(bus.valid), 1);
            check("clr_data", 32'(bus.data_out), 0);
        end
        step(5'b00000, 1'b0, 3'd0);
        step(5'b00000, 1'b0, 3'd0);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
